// File: rtl/sram_io_pkg.sv
// sram_io_pkg: shared FSM states and constants for the SRAM I/O bridge.
package sram_io_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_e;
  localparam logic [19:0] MMIO_ADDR = 20'h0FFFF;
  localparam int WAIT_W = 4;
endpackage

// File: rtl/sram_wait_counter.sv
// sram_wait_counter: loadable down-counter with zero flag timing the SRAM access dwell.
module sram_wait_counter
  import sram_io_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              dec,
  input  logic [WAIT_W-1:0] load_val,
  output logic              zero
);
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = load ? load_val : (dec && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    zero  = cnt_q == '0;
  end
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/sram_io_bridge.sv
// sram_io_bridge: turns single-cycle CPU requests into timed active-low SRAM pin sequences.
// Define SRAM_IO_BRIDGE_MMIO_EN to decode 0xFFFF as switches (read) / hex register (write).
module sram_io_bridge
  import sram_io_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req,
  input  logic        we,
  input  logic [19:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        ack,
  output logic        busy,
  input  logic [15:0] Switches,
  output logic [15:0] hex_out,
  output logic        CE,
  output logic        UB,
  output logic        LB,
  output logic        OE,
  output logic        WE,
  output logic [19:0] ADDR,
  inout  wire  [15:0] Data
);
  state_e      state_q, state_d;
  logic        we_q, we_d, mmio_q, mmio_d;
  logic [19:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d, rdata_q, rdata_d, hex_q, hex_d;
  logic        hit, cnt_zero, sram_act;

`ifdef SRAM_IO_BRIDGE_MMIO_EN
  assign hit = addr == MMIO_ADDR;
`else
  assign hit = 1'b0;
`endif

  sram_wait_counter u_wait (
    .clk     (Clk),
    .rst     (Reset),
    .load    (state_q == SETUP),
    .dec     (state_q == ACCESS),
    .load_val(WAIT_W'(WAIT_CYCLES - 1)),
    .zero    (cnt_zero)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    mmio_d  = mmio_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    hex_d   = hex_q;
    case (state_q)
      IDLE: if (req) begin
        we_d    = we;
        wdata_d = wdata;
        mmio_d  = hit;
        addr_d  = hit ? addr_q : addr;
        state_d = hit ? HOLD : SETUP;
        rdata_d = (hit && !we) ? Switches : rdata_q;
        hex_d   = (hit && we) ? wdata : hex_q;
      end
      SETUP:  state_d = ACCESS;
      ACCESS: if (cnt_zero) begin
        state_d = HOLD;
        rdata_d = we_q ? rdata_q : Data;
      end
      HOLD:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      mmio_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      hex_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      mmio_q  <= mmio_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      hex_q   <= hex_d;
    end
  end

  // MMIO transactions pass through HOLD without touching the SRAM pins
  assign sram_act = busy && !mmio_q;
  assign busy     = state_q != IDLE;
  assign ack      = state_q == HOLD;
  assign CE       = !sram_act;
  assign UB       = CE;
  assign LB       = CE;
  assign OE       = !(sram_act && !we_q && (state_q == SETUP || state_q == ACCESS));
  assign WE       = !(sram_act && we_q && state_q == ACCESS);
  assign Data     = (sram_act && we_q) ? wdata_q : 'z;
  assign ADDR     = addr_q;
  assign rdata    = rdata_q;
  assign hex_out  = hex_q;
endmodule
